cdc_echo_app: RTL

//  Application stage on the usb_cdc byte streams, clocked from the 48MHz USB clock.
//  - Consumes OUT bytes (host->device) from usb_cdc and buffers them in a FIFO.
//  - Optionally upcases bytes and expands CR to CR,LF.
//  - Returns the bytes on the IN stream (device->host).
//  - Drives sleep_o for the top-level LED/idle logic after a traffic-free timeout.

---
 rtl/cdc_app_pkg.sv | 15 +
 rtl/byte_fifo.sv | 56 +++++
 rtl/cdc_echo_app.sv | 106 ++++++++++
 3 files changed

// File: rtl/cdc_app_pkg.sv
// Shared constants and FSM state type for the CDC echo application stage.
package cdc_app_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_a    = 8'h61;
    localparam logic [7:0] ASCII_z    = 8'h7A;
    localparam logic [7:0] CASE_DELTA = 8'h20;

    typedef enum logic {
        PASS,
        INS_LF
    } app_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, power-of-two depth, with occupancy count and a zeroed head when empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == CNT_FULL);
    assign empty_o = (count == '0);
    assign count_o = count;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = empty_o ? 8'h00 : mem[rd_ptr];

    // NOTE: storage has no reset; the head is gated by empty_o, so stale contents never reach data_o.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdc_echo_app.sv
// Echo stage on the usb_cdc byte streams: buffers OUT bytes, optionally upcases
// and expands CR to CR,LF, returns them on IN, and flags a quiet link via sleep_o.
module cdc_echo_app
    import cdc_app_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter bit UPCASE      = 1'b1,
    parameter bit EXPAND_CR   = 1'b1,
    parameter int IDLE_CYCLES = 48000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic       sleep_o
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    function automatic logic [7:0] upcase(input logic [7:0] b);
        if (b >= ASCII_a && b <= ASCII_z) return b - CASE_DELTA;
        return b;
    endfunction

    app_state_e        state;
    logic              run_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        fifo_head;
    logic              out_accept;
    logic              in_accept;
    logic              lf_push;
    logic              is_cr;
    logic              push;
    logic [7:0]        push_data;
    logic              idle_clear;
    logic [IDLE_W-1:0] idle_cnt;
    logic              sleep_q;

    assign out_ready_o = run_q & ~fifo_full & (state == PASS);
    assign out_accept  = out_valid_i & out_ready_o;
    assign in_valid_o  = ~fifo_empty;
    assign in_data_o   = fifo_head;
    assign in_accept   = in_valid_o & in_ready_i;
    assign is_cr       = EXPAND_CR && (out_data_i == ASCII_CR);
    // A pop in the same cycle does not make room for the LF; only a non-full count does.
    assign lf_push     = (state == INS_LF) && (fifo_count < DEPTH_CNT);
    assign idle_clear  = out_accept | in_accept | ~fifo_empty | (state != PASS);
    assign sleep_o     = sleep_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        push      = out_accept | lf_push;
        push_data = UPCASE ? upcase(out_data_i) : out_data_i;
        if (lf_push) push_data = ASCII_LF;
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push_i (push),
        .data_i (push_data),
        .pop_i  (in_accept),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= PASS;
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                PASS:    if (out_accept && is_cr) state <= INS_LF;
                INS_LF:  if (lf_push) state <= PASS;
                default: state <= PASS;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idle_cnt <= '0;
            sleep_q  <= 1'b0;
        end else begin
            if (idle_clear)               idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_ONE;
            sleep_q <= (idle_cnt == IDLE_MAX);
        end
    end

endmodule
